inst_queue: RTL and testbench

Parametrised instruction queue between the fetch and decode stages. It decouples fetch from decode so that each can move a different number of instructions per cycle. Fetch pushes up to IN_WIDTH instructions per beat and decode pops up to OUT_WIDTH per cycle. The queue uses the pipeline's allowin/to_valid handshake on both sides and supports a full flush on redirect or exception.

---
 rtl/iq_pkg.sv | 18 +
 rtl/iq_checker.sv | 16 +
 rtl/iq_storage.sv | 36 +++
 rtl/inst_queue.sv | 122 ++++++++++++
 tb/tb_inst_queue.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_pkg.sv
// Shared types, default geometry and small helpers for the fetch-to-decode instruction queue.
package iq_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   localparam int IQ_DEPTH  = 16;
   localparam int IQ_DATA_W = $bits(iq_entry_t);
   localparam int IQ_PTR_W  = $clog2(IQ_DEPTH);
   localparam int IQ_CNT_W  = $clog2(IQ_DEPTH + 1);

   function automatic logic [31:0] sat_min(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/iq_checker.sv
// Protocol checks on the fetch side of the instruction queue.
module iq_checker #(
   parameter int IN_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fs_to_valid,
   input  logic [$clog2(IN_WIDTH+1)-1:0] fs_in_count
);
   localparam int IN_CW = $clog2(IN_WIDTH + 1);

   // A beat never claims more slots than the fetch bus carries.
   a_in_count_legal: assert property (@(posedge clk) disable iff (!reset)
      fs_to_valid |-> (fs_in_count <= IN_CW'(IN_WIDTH)));

endmodule

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: IN_WIDTH modulo-addressed write ports, OUT_WIDTH read ports.
module iq_storage
   import iq_pkg::*;
#(
   parameter int DEPTH     = IQ_DEPTH,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DATA_W    = IQ_DATA_W
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [$clog2(DEPTH)-1:0]      wr_base,
   input  logic [$clog2(IN_WIDTH+1)-1:0] wr_count,
   input  logic [IN_WIDTH*DATA_W-1:0]    wr_bus,
   input  logic [$clog2(DEPTH)-1:0]      rd_base,
   output logic [OUT_WIDTH*DATA_W-1:0]   rd_bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int IN_CW = $clog2(IN_WIDTH + 1);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Contents are deliberately left unreset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
         if (wr_en && (IN_CW'(j) < wr_count)) begin
            mem_r[wr_base + PTR_W'(j)] <= wr_bus[j*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_rd
      assign rd_bus[k*DATA_W +: DATA_W] = mem_r[rd_base + PTR_W'(k)];
   end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with allowin/to_valid handshakes and flush.
// Optional same-cycle bypass of fetch slots into empty output slots: define IQ_BYPASS_EN.
module inst_queue
   import iq_pkg::*;
#(
   parameter int DEPTH     = IQ_DEPTH,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DATA_W    = IQ_DATA_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           fs_to_valid,
   input  logic [$clog2(IN_WIDTH+1)-1:0]  fs_in_count,
   input  logic [IN_WIDTH*DATA_W-1:0]     fs_to_iq_bus,
   output logic                           iq_allowin,
   input  logic                           ds_allowin,
   input  logic [$clog2(OUT_WIDTH+1)-1:0] ds_pop_count,
   output logic                           iq_to_valid,
   output logic [OUT_WIDTH-1:0]           iq_out_valid,
   output logic [OUT_WIDTH*DATA_W-1:0]    iq_to_ds_bus,
   output logic [$clog2(DEPTH+1)-1:0]     iq_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IN_CW = $clog2(IN_WIDTH + 1);

   logic [PTR_W-1:0]            head_r, tail_r;
   logic [CNT_W-1:0]            count_r;
   logic                        push_s, wr_en_s;
   logic [CNT_W-1:0]            push_n_s, avail_s, pop_n_s, skip_s;
   logic [PTR_W-1:0]            wr_base_s;
   logic [IN_CW-1:0]            wr_count_s;
   logic [IN_WIDTH*DATA_W-1:0]  wr_bus_s;
   logic [OUT_WIDTH*DATA_W-1:0] rd_bus_s;
   logic [OUT_WIDTH-1:0]        out_valid_s;
   logic [OUT_WIDTH*DATA_W-1:0] out_bus_s;

   // Only registered occupancy feeds allowin, so decode never reaches fetch combinationally.
   assign iq_allowin = (CNT_W'(DEPTH) - count_r) >= CNT_W'(IN_WIDTH);

   // Push/pop amounts; skip_s counts bypassed fetch slots consumed before reaching storage.
   always_comb begin
      push_s     = fs_to_valid && iq_allowin && (fs_in_count != '0);
      push_n_s   = push_s ? CNT_W'(fs_in_count) : '0;
`ifdef IQ_BYPASS_EN
      avail_s    = (count_r < CNT_W'(OUT_WIDTH)) ? count_r + push_n_s : count_r;
`else
      avail_s    = count_r;
`endif
      pop_n_s    = ds_allowin ? CNT_W'(sat_min(32'(ds_pop_count), 32'(avail_s))) : '0;
      skip_s     = (pop_n_s > count_r) ? pop_n_s - count_r : '0;
      wr_en_s    = push_s && !flush && (push_n_s > skip_s);
      wr_base_s  = tail_r + PTR_W'(skip_s);
      wr_count_s = IN_CW'(push_n_s - skip_s);
      wr_bus_s   = fs_to_iq_bus >> (32'(skip_s) * DATA_W);
   end

   // Output view: stored entries first, then (with bypass) incoming fetch slots.
   always_comb begin
      out_valid_s = '0;
      out_bus_s   = '0;
      for (int k = 0; k < OUT_WIDTH; k++) begin
         out_valid_s[k] = CNT_W'(k) < avail_s;
         if (CNT_W'(k) < count_r) begin
            out_bus_s[k*DATA_W +: DATA_W] = rd_bus_s[k*DATA_W +: DATA_W];
         end else if (out_valid_s[k]) begin
            out_bus_s[k*DATA_W +: DATA_W] = DATA_W'(fs_to_iq_bus >> ((k - int'(count_r)) * DATA_W));
         end else begin
            out_bus_s[k*DATA_W +: DATA_W] = '0;
         end
      end
   end

   // Pointer and occupancy state; flush discards any push or pop in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (flush) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         head_r  <= head_r + PTR_W'(pop_n_s);
         tail_r  <= tail_r + PTR_W'(push_n_s);
         count_r <= count_r + push_n_s - pop_n_s;
      end
   end

   assign iq_out_valid = out_valid_s;
   assign iq_to_valid  = |out_valid_s;
   assign iq_to_ds_bus = out_bus_s;
   assign iq_count     = count_r;

   iq_storage #(
      .DEPTH     (DEPTH),
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .DATA_W    (DATA_W)
   ) u_storage (
      .clk      (clk),
      .wr_en    (wr_en_s),
      .wr_base  (wr_base_s),
      .wr_count (wr_count_s),
      .wr_bus   (wr_bus_s),
      .rd_base  (head_r),
      .rd_bus   (rd_bus_s)
   );

   iq_checker #(
      .IN_WIDTH (IN_WIDTH)
   ) u_checker (
      .clk         (clk),
      .reset       (reset),
      .fs_to_valid (fs_to_valid),
      .fs_in_count (fs_in_count)
   );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=8) against a queue-based reference model.
module tb_inst_queue;
   localparam int DEPTH = 8, IN_WIDTH = 2, OUT_WIDTH = 2, DATA_W = 64;

   logic         clk = 1'b0;
   logic         reset, flush, fs_to_valid, ds_allowin;
   logic [1:0]   fs_in_count, ds_pop_count;
   logic [127:0] fs_to_iq_bus;
   logic         iq_allowin, iq_to_valid;
   logic [1:0]   iq_out_valid;
   logic [127:0] iq_to_ds_bus;
   logic [3:0]   iq_count;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] mq[$];

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .flush(flush), .fs_to_valid(fs_to_valid),
      .fs_in_count(fs_in_count), .fs_to_iq_bus(fs_to_iq_bus), .iq_allowin(iq_allowin),
      .ds_allowin(ds_allowin), .ds_pop_count(ds_pop_count), .iq_to_valid(iq_to_valid),
      .iq_out_valid(iq_out_valid), .iq_to_ds_bus(iq_to_ds_bus), .iq_count(iq_count)
   );

   // ---------------- reference model ----------------
   function automatic int pushn_now();
      return (fs_to_valid && (DEPTH - mq.size() >= IN_WIDTH) && fs_in_count != 2'd0) ? int'(fs_in_count) : 0;
   endfunction

   function automatic logic [63:0] fs_slot(input int j);
      return fs_to_iq_bus[j*64 +: 64];
   endfunction

   function automatic int exp_avail();
      int sz = mq.size();
`ifdef IQ_BYPASS_EN
      if (sz < OUT_WIDTH) return sz + pushn_now();
`endif
      return sz;
   endfunction

   function automatic logic [1:0] exp_valid();
      logic [1:0] v = 2'b00;
      for (int k = 0; k < OUT_WIDTH; k++) v[k] = (k < exp_avail());
      return v;
   endfunction

   function automatic logic [127:0] exp_bus();
      logic [127:0] b = '0;
      int sz = mq.size();
      for (int k = 0; k < OUT_WIDTH; k++) begin
         if (k < sz) b[k*64 +: 64] = mq[k];
         else if (k < exp_avail()) b[k*64 +: 64] = fs_slot(k - sz);
      end
      return b;
   endfunction

   task automatic model_edge();
      int pn, avail, pop;
      if (flush) begin
         mq.delete();
         return;
      end
      pn    = pushn_now();
      avail = exp_avail();
      pop   = ds_allowin ? ((int'(ds_pop_count) < avail) ? int'(ds_pop_count) : avail) : 0;
      for (int j = 0; j < pn; j++) mq.push_back(fs_slot(j));
      repeat (pop) void'(mq.pop_front());
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n, input logic [31:0] pc, input logic dsa, input int popc);
      fs_to_valid  = v;
      fs_in_count  = 2'(n);
      fs_to_iq_bus = {pc + 32'd4, 32'($urandom), pc, 32'($urandom)};
      ds_allowin   = dsa;
      ds_pop_count = 2'(popc);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, 0, 32'h0, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", iq_count); end
      vectors++; if (iq_out_valid !== 2'b00) begin miscompares++; $display("FAIL reset_valid: got %b, expected 00", iq_out_valid); end
      vectors++; if (iq_to_valid !== 1'b0) begin miscompares++; $display("FAIL reset_to_valid: got %b, expected 0", iq_to_valid); end
      vectors++; if (iq_allowin !== 1'b1) begin miscompares++; $display("FAIL reset_allowin: got %b, expected 1", iq_allowin); end
      vectors++; if (iq_to_ds_bus !== 128'd0) begin miscompares++; $display("FAIL reset_bus: got %h, expected 0", iq_to_ds_bus); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++; if (iq_count !== 4'd0 || iq_to_valid !== 1'b0 || iq_allowin !== 1'b1) begin
         miscompares++; $display("FAIL release: got count=%0d to_valid=%b allowin=%b, expected 0/0/1", iq_count, iq_to_valid, iq_allowin);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2, 32'hbfc00000 + 32'(8*i), 1'b0, 0);
         tick();
         vectors++; if (iq_count !== 4'(2*(i+1))) begin miscompares++; $display("FAIL fill_count: got %0d, expected %0d", iq_count, 2*(i+1)); end
         vectors++; if (iq_allowin !== (2*(i+1) <= 6)) begin miscompares++; $display("FAIL fill_allowin: got %b, expected %b", iq_allowin, (2*(i+1) <= 6)); end
      end
      drive(1'b1, 2, 32'hbfc00020, 1'b0, 0);
      tick();
      vectors++; if (iq_count !== 4'd8) begin miscompares++; $display("FAIL full_reject_count: got %0d, expected 8", iq_count); end
      vectors++; if (iq_to_ds_bus[63:32] !== 32'hbfc00000 || iq_to_ds_bus[127:96] !== 32'hbfc00004) begin
         miscompares++; $display("FAIL full_head: got %h/%h, expected bfc00000/bfc00004", iq_to_ds_bus[63:32], iq_to_ds_bus[127:96]);
      end
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 0, 32'h0, 1'b1, 2);
         #1;
         vectors++; if (iq_out_valid !== exp_valid()) begin miscompares++; $display("FAIL drain_valid: got %b, expected %b", iq_out_valid, exp_valid()); end
         vectors++; if (iq_to_ds_bus !== exp_bus()) begin miscompares++; $display("FAIL drain_bus: got %h, expected %h", iq_to_ds_bus, exp_bus()); end
         tick();
      end
      vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("FAIL drain_empty: got %0d, expected 0", iq_count); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc = 32'hbfc00000;
      int fed = 0;
      for (int c = 0; c < 30; c++) begin
         drive(fed < 20, 2, 32'hbfc00000 + 32'(8*fed), 1'b1, 2);
         #1;
         vectors++; if (iq_count !== 4'(mq.size())) begin miscompares++; $display("FAIL stream_count: got %0d, expected %0d", iq_count, mq.size()); end
         vectors++; if (iq_to_ds_bus !== exp_bus()) begin miscompares++; $display("FAIL stream_bus: got %h, expected %h", iq_to_ds_bus, exp_bus()); end
         if (c >= 1 && c < 20) begin
            vectors++; if (iq_out_valid !== 2'b11) begin miscompares++; $display("FAIL stream_gap: got %b, expected 11 at cycle %0d", iq_out_valid, c); end
         end
         if (iq_to_valid) begin
            vectors++; if (iq_to_ds_bus[63:32] !== exp_pc) begin miscompares++; $display("FAIL stream_order: got %h, expected %h", iq_to_ds_bus[63:32], exp_pc); end
            exp_pc = exp_pc + 32'(4 * (int'(iq_out_valid[0]) + int'(iq_out_valid[1])));
         end
         if (fs_to_valid && (DEPTH - mq.size() >= IN_WIDTH)) fed++;
         tick();
      end
      vectors++; if (exp_pc !== 32'hbfc00000 + 32'd160) begin miscompares++; $display("FAIL stream_total: got %h, expected %h", exp_pc, 32'hbfc000a0); end
      vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("FAIL stream_empty: got %0d, expected 0", iq_count); end
   endtask

   task automatic test_partial_pop();
      drive(1'b1, 1, 32'h80000000, 1'b0, 0);
      tick();
      drive(1'b0, 0, 32'h0, 1'b1, 2);
      #1;
      vectors++; if (iq_out_valid !== 2'b01) begin miscompares++; $display("FAIL partial_valid: got %b, expected 01", iq_out_valid); end
      vectors++; if (iq_to_ds_bus[63:32] !== 32'h80000000 || iq_to_ds_bus[127:64] !== 64'd0) begin
         miscompares++; $display("FAIL partial_bus: got %h, expected slot0 pc 80000000, slot1 0", iq_to_ds_bus);
      end
      tick();
      vectors++; if (iq_count !== 4'd0 || iq_to_valid !== 1'b0) begin miscompares++; $display("FAIL partial_after: got count=%0d to_valid=%b, expected 0/0", iq_count, iq_to_valid); end
   endtask

   task automatic test_flush();
      drive(1'b1, 2, 32'ha0000000, 1'b0, 0); tick();
      drive(1'b1, 2, 32'ha0000008, 1'b0, 0); tick();
      drive(1'b1, 1, 32'ha0000010, 1'b0, 0); tick();
      vectors++; if (iq_count !== 4'd5) begin miscompares++; $display("FAIL flush_pre: got %0d, expected 5", iq_count); end
      flush = 1'b1;
      drive(1'b1, 2, 32'ha0000020, 1'b1, 2);
      tick();
      flush = 1'b0;
      drive(1'b0, 0, 32'h0, 1'b0, 0);
      #1;
      vectors++; if (iq_count !== 4'd0 || iq_to_valid !== 1'b0 || iq_allowin !== 1'b1) begin
         miscompares++; $display("FAIL flush_clear: got count=%0d to_valid=%b allowin=%b, expected 0/0/1", iq_count, iq_to_valid, iq_allowin);
      end
      drive(1'b1, 1, 32'h90000000, 1'b0, 0);
      tick();
      drive(1'b0, 0, 32'h0, 1'b0, 0);
      #1;
      vectors++; if (iq_out_valid !== 2'b01 || iq_to_ds_bus[63:32] !== 32'h90000000) begin
         miscompares++; $display("FAIL flush_refill: got valid=%b pc=%h, expected 01/90000000", iq_out_valid, iq_to_ds_bus[63:32]);
      end
      drive(1'b0, 0, 32'h0, 1'b1, 2);
      tick();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 2, 32'hd0000000, 1'b0, 0); tick();
      drive(1'b1, 2, 32'hd0000008, 1'b0, 0); tick();
      vectors++; if (iq_count !== 4'd4) begin miscompares++; $display("FAIL areset_pre: got %0d, expected 4", iq_count); end
      drive(1'b0, 0, 32'h0, 1'b0, 0);
      #2;
      reset = 1'b0;
      #1;
      mq.delete();
      vectors++; if (iq_count !== 4'd0 || iq_out_valid !== 2'b00 || iq_to_valid !== 1'b0) begin
         miscompares++; $display("FAIL areset_state: got count=%0d valid=%b to_valid=%b, expected 0/00/0", iq_count, iq_out_valid, iq_to_valid);
      end
      vectors++; if (iq_to_ds_bus !== 128'd0 || iq_allowin !== 1'b1) begin
         miscompares++; $display("FAIL areset_out: got bus=%h allowin=%b, expected 0/1", iq_to_ds_bus, iq_allowin);
      end
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
`ifdef IQ_BYPASS_EN
      drive(1'b1, 2, 32'hc0000000, 1'b1, 2);
      #1;
      vectors++; if (iq_out_valid !== 2'b11 || iq_to_ds_bus[63:32] !== 32'hc0000000) begin
         miscompares++; $display("FAIL bypass_view: got valid=%b pc=%h, expected 11/c0000000", iq_out_valid, iq_to_ds_bus[63:32]);
      end
      tick();
      vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("FAIL bypass_count: got %0d, expected 0", iq_count); end
`endif
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         flush = ($urandom_range(0, 29) == 0);
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 32'h00400000 + 32'(8*c),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
         #1;
         vectors++; if (iq_count !== 4'(mq.size())) begin miscompares++; $display("FAIL rnd_count: got %0d, expected %0d", iq_count, mq.size()); end
         vectors++; if (iq_out_valid !== exp_valid()) begin miscompares++; $display("FAIL rnd_valid: got %b, expected %b", iq_out_valid, exp_valid()); end
         vectors++; if (iq_to_ds_bus !== exp_bus()) begin miscompares++; $display("FAIL rnd_bus: got %h, expected %h", iq_to_ds_bus, exp_bus()); end
         vectors++; if (iq_allowin !== (DEPTH - mq.size() >= IN_WIDTH)) begin miscompares++; $display("FAIL rnd_allowin: got %b, expected %b", iq_allowin, (DEPTH - mq.size() >= IN_WIDTH)); end
         vectors++; if (iq_to_valid !== (exp_valid() != 2'b00)) begin miscompares++; $display("FAIL rnd_to_valid: got %b, expected %b", iq_to_valid, (exp_valid() != 2'b00)); end
         tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_partial_pop();
      test_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
